// File: rtl/cvi_stream_pkg.sv
// Shared constants and helpers for the CVI stream output stage.
//   PKT_TYPE_IMAGE / PKT_TYPE_CTRL : low nibble of symbol 0 on an SOP beat
//   STOP_AT_IMAGE / STOP_AT_ANY    : values of the STOP_MODE parameter
//   clog2()                        : ceiling log2 usable in constant expressions
package cvi_stream_pkg;

  localparam logic [3:0] PKT_TYPE_IMAGE = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

  localparam int unsigned STOP_AT_IMAGE = 0;
  localparam int unsigned STOP_AT_ANY   = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cvi_stream_output_sync_fifo_if.sv
// Avalon-ST style video beat bus used on both sides of the output stage.
//   valid/ready : handshake, a beat moves when both are high
//   data        : DATA_WIDTH bits of pixel symbols
//   sop/eop     : packet delimiters
// The master drives valid/data/sop/eop, the slave drives ready.
interface cvi_stream_output_sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 20
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (
    output valid,
    output data,
    output sop,
    output eop,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  sop,
    input  eop,
    output ready
  );

endinterface

// File: rtl/cvi_stream_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full, even if popping this cycle)
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, forced to zero while empty
//   full, empty, level : occupancy status, all registered
module cvi_stream_fifo
  import cvi_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DepthL);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cvi_stream_output_sync_fifo.sv
// Output stage of the clocked-video-input stream path.
// Buffers beats from the packetiser in a small show-ahead FIFO, applies the
// requested enable only at packet boundaries so downstream never sees a
// truncated frame, and counts image packets that have left on dout.
//   clk, rst    : clock, asynchronous active-high reset
//   int_bus     : beats from the sync/packetiser logic (slave side)
//   dout_bus    : Avalon-ST video output (master side)
//   enable      : requested stream enable (level)
//   synced      : applied enable matches the request
//   frame_count : image packets fully output since reset (wraps)
//   fifo_level  : current FIFO occupancy
module cvi_stream_output_sync_fifo
  import cvi_stream_pkg::*;
#(
  parameter int unsigned BPS                = 10,
  parameter int unsigned SYMBOLS_PER_BEAT   = 2,
  parameter int unsigned PIXELS_IN_PARALLEL = 1,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned STOP_MODE          = STOP_AT_IMAGE,
  parameter int unsigned FRAME_COUNT_WIDTH  = 16,
  localparam int unsigned DATA_WIDTH        = BPS * SYMBOLS_PER_BEAT * PIXELS_IN_PARALLEL,
  localparam int unsigned LEVEL_WIDTH       = clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  cvi_stream_output_sync_fifo_if.slave  int_bus,
  cvi_stream_output_sync_fifo_if.master dout_bus,
  input  logic                         enable,
  output logic                         synced,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic [LEVEL_WIDTH-1:0]       fifo_level
);

  localparam int unsigned FifoWidth = DATA_WIDTH + 2;

  logic                         enable_applied_q;
  logic                         boundary_q;
  logic                         in_image_q;
  logic                         out_in_image_q;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FifoWidth-1:0] head;
  logic                 int_ready;
  logic                 push;
  logic                 pop;
  logic                 acc_sop;
  logic                 acc_eop;
  logic                 sop_image;
  logic                 boundary_nxt;
  logic                 head_sop;
  logic                 head_eop;
  logic                 head_image;
  logic                 image_eop_out;

  // Registers only: dout_ready never reaches int_ready combinationally.
  assign int_ready     = enable_applied_q & ~fifo_full;
  assign int_bus.ready = int_ready;

  assign push      = int_bus.valid & int_ready;
  assign pop       = ~fifo_empty & dout_bus.ready;
  assign acc_sop   = push & int_bus.sop;
  assign acc_eop   = push & int_bus.eop;
  assign sop_image = int_bus.sop & (int_bus.data[3:0] == PKT_TYPE_IMAGE);

  cvi_stream_fifo #(
    .WIDTH (FifoWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({int_bus.sop, int_bus.eop, int_bus.data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign head_sop   = head[FifoWidth-1];
  assign head_eop   = head[FifoWidth-2];
  assign head_image = head_sop & (head[3:0] == PKT_TYPE_IMAGE);

  assign dout_bus.valid = ~fifo_empty;
  assign dout_bus.sop   = head_sop;
  assign dout_bus.eop   = head_eop;
  assign dout_bus.data  = head[DATA_WIDTH-1:0];

  // In image-boundary mode a control packet keeps the boundary closed until
  // the following image packet ends, so the pair is never split.
  always_comb begin
    boundary_nxt = boundary_q & ~acc_sop;
    if (STOP_MODE == STOP_AT_ANY) begin
      boundary_nxt = acc_eop | boundary_nxt;
    end else begin
      boundary_nxt = (acc_eop & (in_image_q | sop_image)) | boundary_nxt;
    end
  end

  // A single-beat image packet carries SOP and EOP at the head together.
  assign image_eop_out = pop & head_eop & (out_in_image_q | head_image);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_applied_q <= 1'b0;
      boundary_q       <= 1'b1;
      in_image_q       <= 1'b0;
      out_in_image_q   <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      boundary_q <= boundary_nxt;
      if (boundary_nxt) enable_applied_q <= enable;

      if (acc_eop)      in_image_q <= 1'b0;
      else if (acc_sop) in_image_q <= sop_image;

      if (pop) begin
        if (head_eop)      out_in_image_q <= 1'b0;
        else if (head_sop) out_in_image_q <= head_image;
      end

      if (image_eop_out) frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign synced      = (enable_applied_q == enable);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cvi_stream_output_sync_fifo.sv
module tb_cvi_stream_output_sync_fifo;

  localparam int unsigned DW    = 20;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          int_valid;
  logic          int_sop;
  logic          int_eop;
  logic [DW-1:0] int_data;
  logic          dout_ready;

  logic          synced0, synced1;
  logic [15:0]   frame_count0, frame_count1;
  logic [2:0]    fifo_level0, fifo_level1;

  int checks;
  int errors;

  // Reference model of the STOP_MODE=0 instance: a queue of buffered beats
  // plus "packet open" tracking that gates when the enable request lands.
  beat_t       m_q[$];
  bit          m_applied;
  bit          m_open;
  bit          m_pkt_img;
  bit          m_out_img;
  logic [15:0] m_frames;

  cvi_stream_output_sync_fifo_if #(.DATA_WIDTH(DW)) in0 ();
  cvi_stream_output_sync_fifo_if #(.DATA_WIDTH(DW)) out0 ();
  cvi_stream_output_sync_fifo_if #(.DATA_WIDTH(DW)) in1 ();
  cvi_stream_output_sync_fifo_if #(.DATA_WIDTH(DW)) out1 ();

  assign in0.valid  = int_valid;
  assign in0.sop    = int_sop;
  assign in0.eop    = int_eop;
  assign in0.data   = int_data;
  assign out0.ready = dout_ready;
  assign in1.valid  = int_valid;
  assign in1.sop    = int_sop;
  assign in1.eop    = int_eop;
  assign in1.data   = int_data;
  assign out1.ready = dout_ready;

  cvi_stream_output_sync_fifo #(
    .BPS(10), .SYMBOLS_PER_BEAT(2), .PIXELS_IN_PARALLEL(1),
    .FIFO_DEPTH(DEPTH), .STOP_MODE(0), .FRAME_COUNT_WIDTH(16)
  ) dut0 (
    .clk(clk), .rst(rst), .int_bus(in0), .dout_bus(out0), .enable(enable),
    .synced(synced0), .frame_count(frame_count0), .fifo_level(fifo_level0)
  );

  cvi_stream_output_sync_fifo #(
    .BPS(10), .SYMBOLS_PER_BEAT(2), .PIXELS_IN_PARALLEL(1),
    .FIFO_DEPTH(DEPTH), .STOP_MODE(1), .FRAME_COUNT_WIDTH(16)
  ) dut1 (
    .clk(clk), .rst(rst), .int_bus(in1), .dout_bus(out1), .enable(enable),
    .synced(synced1), .frame_count(frame_count1), .fifo_level(fifo_level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_ready();
    return m_applied && (m_q.size() < DEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_applied = 1'b0;
    m_open    = 1'b0;
    m_pkt_img = 1'b0;
    m_out_img = 1'b0;
    m_frames  = '0;
  endtask

  // One clock: predict the handshakes from pre-edge values, then advance the model.
  task automatic step();
    bit    push, pop;
    beat_t b, h;
    push   = int_valid && model_ready();
    pop    = (m_q.size() != 0) && dout_ready;
    b.sop  = int_sop;
    b.eop  = int_eop;
    b.data = int_data;
    @(posedge clk);
    #1;
    if (pop) begin
      h = m_q.pop_front();
      if (h.sop) m_out_img = (h.data[3:0] == 4'h0);
      if (h.eop && m_out_img) m_frames = m_frames + 16'd1;
    end
    if (push) begin
      m_q.push_back(b);
      if (b.sop) begin
        m_open    = 1'b1;
        m_pkt_img = (b.data[3:0] == 4'h0);
      end
      if (b.eop && m_pkt_img) m_open = 1'b0;
    end
    if (!m_open) m_applied = enable;
  endtask

  // Offer one beat until the model says it was taken (bounded).
  task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d);
    bit done;
    done      = 1'b0;
    int_valid = 1'b1;
    int_sop   = sop;
    int_eop   = eop;
    int_data  = d;
    for (int c = 0; c < 64 && !done; c++) begin
      done = model_ready();
      step();
    end
    int_valid = 1'b0;
    int_sop   = 1'b0;
    int_eop   = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: beat %h not accepted (got no ready, required accept)", d);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    int_valid  = 1'b0;
    int_sop    = 1'b0;
    int_eop    = 1'b0;
    int_data   = '0;
    dout_ready = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    checks++; if (out0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out0.valid); end
    checks++; if (out0.data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out0.data); end
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in0.ready); end
    checks++; if (fifo_level0 !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level0); end
    checks++; if (frame_count0 !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", frame_count0); end
    checks++; if (in1.ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", in1.ready); end
    rst = 1'b0;
    step();
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL reset_disabled_ready got=%b exp=0", in0.ready); end
    checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL reset_synced got=%b exp=1", synced0); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d [3];
    d[0] = 20'h00000; d[1] = 20'h00155; d[2] = 20'h002AA;
    enable = 1'b1;
    step();
    checks++; if (in0.ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", in0.ready); end
    for (int i = 0; i < 3; i++) begin
      send(i == 0, i == 2, d[i]);
      checks++; if (out0.valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, out0.valid); end
      checks++; if (out0.data !== d[i]) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, out0.data, d[i]); end
      checks++; if ({out0.sop, out0.eop} !== {i == 0, i == 2}) begin errors++; $display("FAIL basic_flags[%0d] got=%b%b", i, out0.sop, out0.eop); end
      checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL basic_synced[%0d] got=%b exp=1", i, synced0); end
    end
    step();
    checks++; if (out0.valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b exp=0", out0.valid); end
    checks++; if (frame_count0 !== 16'd1) begin errors++; $display("FAIL basic_frames got=%0d exp=1", frame_count0); end
  endtask

  task automatic test_disable_mid();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) enable = 1'b0;
      send(i == 0, i == 4, 20'h00100 + 20'(i * 16));
      checks++; if (out0.data !== m_q[0].data) begin errors++; $display("FAIL dis_data[%0d] got=%h exp=%h", i, out0.data, m_q[0].data); end
      if (i < 4) begin
        checks++; if (in0.ready !== 1'b1) begin errors++; $display("FAIL dis_ready[%0d] got=%b exp=1", i, in0.ready); end
        checks++; if (synced0 !== (i == 0)) begin errors++; $display("FAIL dis_synced[%0d] got=%b exp=%b", i, synced0, i == 0); end
      end
    end
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL dis_ready_after_eop got=%b exp=0", in0.ready); end
    checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL dis_synced_after_eop got=%b exp=1", synced0); end
    step();
    step();
    checks++; if (frame_count0 !== 16'd2) begin errors++; $display("FAIL dis_frames got=%0d exp=2", frame_count0); end
    checks++; if (out0.valid !== 1'b0) begin errors++; $display("FAIL dis_drained got=%b exp=0", out0.valid); end
  endtask

  task automatic test_stop_mode();
    logic [DW-1:0] img [3];
    img[0] = 20'h003A0; img[1] = 20'h00111; img[2] = 20'h00222;
    enable     = 1'b1;
    dout_ready = 1'b1;
    apply_reset();
    step();
    send(1'b1, 1'b0, 20'h0000F);
    enable = 1'b0;
    send(1'b0, 1'b1, 20'h00123);
    checks++; if (in0.ready !== 1'b1) begin errors++; $display("FAIL stop0_ready_ctrl got=%b exp=1", in0.ready); end
    checks++; if (in1.ready !== 1'b0) begin errors++; $display("FAIL stop1_ready_ctrl got=%b exp=0", in1.ready); end
    checks++; if (synced0 !== 1'b0) begin errors++; $display("FAIL stop0_synced_ctrl got=%b exp=0", synced0); end
    checks++; if (synced1 !== 1'b1) begin errors++; $display("FAIL stop1_synced_ctrl got=%b exp=1", synced1); end
    for (int i = 0; i < 3; i++) begin
      send(i == 0, i == 2, img[i]);
      checks++; if (out0.data !== img[i]) begin errors++; $display("FAIL stop0_data[%0d] got=%h exp=%h", i, out0.data, img[i]); end
      checks++; if (in0.ready !== model_ready()) begin errors++; $display("FAIL stop0_ready[%0d] got=%b exp=%b", i, in0.ready, model_ready()); end
      checks++; if (in1.ready !== 1'b0) begin errors++; $display("FAIL stop1_blocked[%0d] got=%b exp=0", i, in1.ready); end
    end
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL stop0_ready_img_eop got=%b exp=0", in0.ready); end
    step();
    step();
    checks++; if (frame_count0 !== 16'd1) begin errors++; $display("FAIL stop0_frames got=%0d exp=1", frame_count0); end
    checks++; if (frame_count1 !== 16'd0) begin errors++; $display("FAIL stop1_frames got=%0d exp=0", frame_count1); end
    checks++; if (out1.valid !== 1'b0) begin errors++; $display("FAIL stop1_valid got=%b exp=0", out1.valid); end
    checks++; if (fifo_level1 !== 3'd0) begin errors++; $display("FAIL stop1_level got=%0d exp=0", fifo_level1); end
  endtask

  task automatic test_full();
    int idx;
    bit acc;
    idx    = 0;
    enable = 1'b1;
    step();
    dout_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      int_valid = (idx < 6);
      int_sop   = (idx == 0);
      int_eop   = (idx == 5);
      int_data  = 20'h00100 + 20'(idx);
      acc = int_valid && model_ready();
      step();
      if (acc) idx++;
    end
    checks++; if (fifo_level0 !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", fifo_level0); end
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in0.ready); end
    checks++; if (out0.data !== 20'h00100) begin errors++; $display("FAIL full_head got=%h exp=00100", out0.data); end
    dout_ready = 1'b1;
    for (int c = 0; c < 40 && !(idx == 6 && m_q.size() == 0); c++) begin
      int_valid = (idx < 6);
      int_sop   = (idx == 0);
      int_eop   = (idx == 5);
      int_data  = 20'h00100 + 20'(idx);
      acc = int_valid && model_ready();
      step();
      if (acc) idx++;
      checks++; if (in0.ready !== model_ready()) begin errors++; $display("FAIL full_ready_c%0d got=%b exp=%b", c, in0.ready, model_ready()); end
      checks++; if (out0.valid !== (m_q.size() != 0)) begin errors++; $display("FAIL full_valid_c%0d got=%b exp=%b", c, out0.valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (out0.data !== m_q[0].data) begin errors++; $display("FAIL full_order_c%0d got=%h exp=%h", c, out0.data, m_q[0].data); end
      end
    end
    int_valid = 1'b0;
    checks++; if (idx != 6 || m_q.size() != 0) begin errors++; $display("FAIL full_complete got=%0d beats exp=6", idx); end
  endtask

  task automatic test_random();
    int          frame, beat, cyc;
    bit          acc, pv, pr;
    logic [DW-1:0] pd;
    logic [31:0] r;
    logic [15:0] base;
    base  = m_frames;
    frame = 0;
    beat  = 0;
    enable = 1'b1;
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (frame == 100 && m_q.size() == 0) break;
      r          = $urandom;
      int_valid  = (frame < 100) && ($urandom_range(3) != 0);
      int_sop    = (beat == 0);
      int_eop    = (beat == 15);
      int_data   = (beat == 0) ? {r[15:0], 4'h0} : r[DW-1:0];
      dout_ready = $urandom_range(1);
      pv = out0.valid;
      pr = dout_ready;
      pd = out0.data;
      acc = int_valid && model_ready();
      step();
      if (acc) begin
        beat++;
        if (beat == 16) begin
          beat = 0;
          frame++;
        end
      end
      checks++; if (out0.valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out0.valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if ({out0.sop, out0.eop, out0.data} !== m_q[0]) begin errors++; $display("FAIL rand_beat cyc=%0d got=%h exp=%h", cyc, {out0.sop, out0.eop, out0.data}, m_q[0]); end
      end
      if (pv && !pr) begin
        checks++; if (out0.valid !== 1'b1 || out0.data !== pd) begin errors++; $display("FAIL rand_stall cyc=%0d got=%b/%h exp=1/%h", cyc, out0.valid, out0.data, pd); end
      end
    end
    int_valid  = 1'b0;
    dout_ready = 1'b1;
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout got=%0d frames exp=100", frame); end
    checks++; if (frame_count0 !== base + 16'd100) begin errors++; $display("FAIL rand_frames got=%0d exp=%0d", frame_count0, base + 16'd100); end
  endtask

  task automatic test_async_reset();
    enable     = 1'b1;
    dout_ready = 1'b0;
    step();
    send(1'b1, 1'b0, 20'h005A0);
    send(1'b0, 1'b0, 20'h000A1);
    send(1'b0, 1'b0, 20'h000B2);
    checks++; if (fifo_level0 !== 3'd3) begin errors++; $display("FAIL arst_pre_level got=%0d exp=3", fifo_level0); end
    rst = 1'b1;
    #1;
    checks++; if (out0.valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", out0.valid); end
    checks++; if (out0.data !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0", out0.data); end
    checks++; if (fifo_level0 !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", fifo_level0); end
    checks++; if (frame_count0 !== 16'd0) begin errors++; $display("FAIL arst_frames got=%0d exp=0", frame_count0); end
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", in0.ready); end
    #2;
    model_clear();
    rst = 1'b0;
    #1;
    checks++; if (in0.ready !== 1'b0) begin errors++; $display("FAIL arst_ready_released got=%b exp=0", in0.ready); end
    step();
    checks++; if (in0.ready !== 1'b1) begin errors++; $display("FAIL arst_ready_applied got=%b exp=1", in0.ready); end
    checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL arst_synced got=%b exp=1", synced0); end
    dout_ready = 1'b1;
    send(1'b1, 1'b1, 20'h00770);
    step();
    checks++; if (frame_count0 !== 16'd1) begin errors++; $display("FAIL arst_single_beat_frame got=%0d exp=1", frame_count0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_disable_mid();
    test_stop_mode();
    test_full();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvi_stream_output_sync_fifo.md
Name: cvi_stream_output_sync_fifo

Overview:
Output stage of the clocked-video-input stream path. It is the parametrised successor of the single-register output stage, and adds three things: multi-symbol / multi-pixel beats, a small show-ahead FIFO that decouples internal flow control from dout_ready, and a selectable enable-boundary mode. Enable changes take effect only at a packet boundary, so downstream never sees a truncated frame. It also counts completed image packets, and sits between the CVI sync/packetiser logic and the Avalon-ST video output.

Parameters:
BPS, 10, bits per colour symbol
SYMBOLS_PER_BEAT, 2, symbols per pixel (channels in parallel)
PIXELS_IN_PARALLEL, 1, pixels per beat
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2
STOP_MODE, 0, 0 = enable applied only at image-packet boundaries; 1 = at any packet boundary
FRAME_COUNT_WIDTH, 16, width of frame counter
(derived) DATA_WIDTH = BPS*SYMBOLS_PER_BEAT*PIXELS_IN_PARALLEL

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
int_valid  in  1  internal beat valid
int_ready  out  1  internal ready
int_data  in  DATA_WIDTH  internal beat data
int_sop  in  1  internal start of packet
int_eop  in  1  internal end of packet
dout_valid  out  1  output beat valid
dout_ready  in  1  output ready
dout_data  out  DATA_WIDTH  output beat data
dout_sop  out  1  output start of packet
dout_eop  out  1  output end of packet
enable  in  1  requested stream enable (level)
synced  out  1  1 when applied enable equals enable
frame_count  out  FRAME_COUNT_WIDTH  image packets fully output since reset
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-packet):
  - FIFO emptied, so dout_valid=0, dout_data/sop/eop=0.
  - enable_applied=0, boundary=1, in_image=0.
  - frame_count=0, fifo_level=0, int_ready=0.
- Handshakes:
  - An input beat is accepted when int_valid & int_ready.
  - An output beat is transferred when dout_valid & dout_ready.
- int_ready = enable_applied & ~full. It is driven from registers only; there is no combinational path from dout_ready.
- FIFO behaviour:
  - Show-ahead. dout_valid = ~empty; dout_data/sop/eop = head entry.
  - A beat accepted in cycle N is presented on dout in cycle N+1 when the FIFO was empty.
  - Simultaneous push and pop: occupancy is unchanged.
  - Push is never accepted when full, including when a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Packet type:
  - An accepted SOP beat is an image packet iff int_data[3:0]==0 (low nibble of symbol 0).
  - in_image is set on an accepted image SOP and cleared on an accepted EOP.
  - A beat carrying both SOP and EOP in one cycle is a complete packet.
- Boundary tracking is on the input side. boundary_nxt:
  - STOP_MODE=0: (accepted EOP & in_image_or_this_sop_image) | (boundary & ~accepted SOP).
  - STOP_MODE=1: accepted EOP | (boundary & ~accepted SOP).
- Enable application:
  - enable_applied <= enable whenever boundary_nxt=1; otherwise it holds.
  - A disable request mid-packet therefore keeps accepting beats until the boundary EOP; int_ready drops the cycle after that EOP.
  - A control packet followed by an image packet (mode 0) is never split.
- Draining: beats already in the FIFO always drain after disable. No beat is discarded except on reset.
- synced = (enable_applied == enable), combinational.
- frame_count:
  - Increments by 1 on each output-side transfer of an EOP belonging to an image packet. An output-side in_image flag, decoded the same way from the dout head, tracks this.
  - Wraps at 2^FRAME_COUNT_WIDTH.
- Throughput: 1 beat/cycle sustained while dout_ready=1 and enable_applied=1.

Decomposition:
- Package cvi_stream_pkg holds:
  - PKT_TYPE_IMAGE = 4'h0
  - PKT_TYPE_CTRL = 4'hF
  - STOP_AT_IMAGE = 0 and STOP_AT_ANY = 1
  - a clog2 helper function
- Sub-module cvi_stream_fifo: show-ahead FIFO of width DATA_WIDTH+2 and depth FIFO_DEPTH, with full/empty/level outputs. Boundary/enable logic and the frame counter stay in the top module.

Test Plan:
- Reset, enable=1, 3-beat image packet (SOP data 0x000, 0x155, EOP 0x2AA), dout_ready=1 -> beats appear 1 cycle after acceptance in order; frame_count=1; synced=1 throughout.
- enable dropped on beat 2 of a 5-beat image packet -> all 5 beats accepted; int_ready=0 from the cycle after the EOP; synced=0 until then, 1 after; frame_count=1.
- STOP_MODE=0: control packet (SOP data 0x00F, 2 beats), then disable, then image packet -> image packet fully passed; enable applied only after the image EOP. STOP_MODE=1: enable applied after the control EOP and the image packet is blocked.
- FIFO_DEPTH=4, dout_ready=0 with 6 beats offered -> exactly 4 accepted; fifo_level=4; int_ready=0. Release dout_ready -> 4 beats out in order, then remaining 2 accepted.
- Random dout_ready toggling (50%) over 100 image frames of 16 beats -> no loss or duplication, frame_count=100, no dout_valid drop mid-transfer while dout_ready=0.
- Async reset asserted mid-packet with 3 beats buffered -> dout_valid=0 immediately; fifo_level=0, frame_count=0, int_ready=0 until enable=1 is applied at the post-reset boundary.
